// File: rtl/exec_seq_pkg.sv
// Shared encodings for the exec_seq control sequencer: FSM states,
// next-PC select codes, fetch response codes and trap cause values.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5,
        ST_HALT  = 3'd6
    } seq_state_e;

    localparam logic [1:0] PCSEL_ADDER = 2'b00;
    localparam logic [1:0] PCSEL_MTVEC = 2'b01;
    localparam logic [1:0] PCSEL_MEPC  = 2'b11;

    localparam logic [1:0] RRESP_OKAY  = 2'b00;

    localparam logic [3:0] MCAUSE_NONE        = 4'd0;
    localparam logic [3:0] MCAUSE_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] MCAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] MCAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL_M     = 4'd11;

    // Access-fault cause for a failed or timed-out load/store.
    function automatic logic [3:0] mem_fault_cause(input logic is_store);
        return is_store ? MCAUSE_STORE_FAULT : MCAUSE_LOAD_FAULT;
    endfunction

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_IWAIT) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/exec_seq_watchdog.sv
// Wait-cycle watchdog for exec_seq: counts cycles spent waiting on the bus
// or LSU and flags expiry once LIMIT-1 is reached.
module seq_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == LAST);

    // Saturates at LAST so a stalled clear cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/exec_seq.sv
// Multi-cycle control sequencer for the single-issue RV32 NPC core.
// Optional build macro SEQ_WATCHDOG_EN adds a wait-state watchdog that traps stalled fetches/accesses.
module exec_seq
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INST_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              if_arvalid,
    output logic [ADDR_W-1:0] if_araddr,
    input  logic              if_arready,
    input  logic              if_rvalid,
    input  logic [INST_W-1:0] if_rdata,
    input  logic [1:0]        if_rresp,
    output logic              if_rready,
    output logic [INST_W-1:0] inst,
    input  logic              dec_mem,
    input  logic              dec_store,
    input  logic              dec_rd_we,
    input  logic              dec_ecall,
    input  logic              dec_mret,
    input  logic              dec_ebreak,
    input  logic              dec_illegal,
    output logic              lsu_req,
    input  logic              lsu_done,
    input  logic              lsu_err,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              rf_we,
    output logic              trap,
    output logic [3:0]        mcause,
    output logic              instret,
    output logic              halt,
    output seq_state_e        state_dbg
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("exec_seq: TIMEOUT must be at least 2");
    end

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [INST_W-1:0] inst_q;
    logic              inst_load;
    logic [3:0]        mcause_q;
    logic [3:0]        mcause_d;
    logic              cause_load;
    logic              wd_expired;

`ifdef SEQ_WATCHDOG_EN
    logic wd_waiting;

    assign wd_waiting = is_wait_state(state_q);

    seq_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!wd_waiting),
        .enable (wd_waiting),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            inst_q   <= '0;
            mcause_q <= MCAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (inst_load) begin
                inst_q <= if_rdata;
            end
            if (cause_load) begin
                mcause_q <= mcause_d;
            end
        end
    end

    // Completion on the bus or LSU always wins over a same-cycle watchdog expiry.
    always_comb begin
        state_d    = state_q;
        inst_load  = 1'b0;
        cause_load = 1'b0;
        mcause_d   = mcause_q;
        case (state_q)
            ST_FETCH: begin
                if (if_arready) begin
                    state_d = ST_IWAIT;
                end
            end
            ST_IWAIT: begin
                if (if_rvalid) begin
                    if (if_rresp == RRESP_OKAY) begin
                        inst_load = 1'b1;
                        state_d   = ST_EXEC;
                    end else begin
                        cause_load = 1'b1;
                        mcause_d   = MCAUSE_IFETCH_FAULT;
                        state_d    = ST_TRAP;
                    end
                end else if (wd_expired) begin
                    cause_load = 1'b1;
                    mcause_d   = MCAUSE_IFETCH_FAULT;
                    state_d    = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    cause_load = 1'b1;
                    mcause_d   = MCAUSE_ILLEGAL;
                    state_d    = ST_TRAP;
                end else if (dec_ebreak) begin
                    state_d = ST_HALT;
                end else if (dec_ecall) begin
                    cause_load = 1'b1;
                    mcause_d   = MCAUSE_ECALL_M;
                    state_d    = ST_TRAP;
                end else if (dec_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (lsu_done) begin
                    if (lsu_err) begin
                        cause_load = 1'b1;
                        mcause_d   = mem_fault_cause(dec_store);
                        state_d    = ST_TRAP;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expired) begin
                    cause_load = 1'b1;
                    mcause_d   = mem_fault_cause(dec_store);
                    state_d    = ST_TRAP;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Handshakes are valid/ready: a transfer happens on any clock edge where
    // both are high; arvalid stays up with a stable araddr until arready, and
    // rready/lsu_req stay up until rvalid/lsu_done (or a watchdog trap).
    always_comb begin
        if_arvalid = 1'b0;
        if_rready  = 1'b0;
        lsu_req    = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PCSEL_ADDER;
        rf_we      = 1'b0;
        trap       = 1'b0;
        instret    = 1'b0;
        halt       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: if_arvalid = 1'b1;
                ST_IWAIT: if_rready  = 1'b1;
                ST_MEM:   lsu_req    = 1'b1;
                ST_WB: begin
                    pc_we   = 1'b1;
                    pc_sel  = dec_mret ? PCSEL_MEPC : PCSEL_ADDER;
                    rf_we   = dec_rd_we & ~dec_mret;
                    instret = 1'b1;
                end
                ST_TRAP: begin
                    trap   = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PCSEL_MTVEC;
                end
                ST_HALT: halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign if_araddr = rst ? '0 : pc;
    assign inst      = inst_q;
    assign mcause    = rst ? MCAUSE_NONE : mcause_q;
    assign state_dbg = rst ? ST_FETCH : state_q;

`ifndef SYNTHESIS
    a_commit_excl : assert property (@(posedge clk) disable iff (rst)
        !((pc_we || rf_we || trap || instret) && (if_arvalid || if_rready || lsu_req)));
    a_commit_has_pc_we : assert property (@(posedge clk) disable iff (rst)
        (rf_we || trap || instret) |-> pc_we);
    a_arvalid_hold : assert property (@(posedge clk) disable iff (rst)
        (if_arvalid && !if_arready) |=> if_arvalid);
`endif

endmodule
